// File: rtl/csd_conv_ctrl_if.sv
// Handshake and memory-port bundle between the host side and the CSD
// conversion controller; slave is the controller, master is the host/memories.
interface csd_conv_ctrl_if #(
    parameter int AW = 4
);
    logic          start;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [1:0]    wr_data;
    logic [AW-1:0] nz_count;

    modport slave (
        input  start,
        input  rd_data,
        output busy,
        output done,
        output rd_en,
        output rd_addr,
        output wr_en,
        output wr_addr,
        output wr_data,
        output nz_count
    );

    modport master (
        output start,
        output rd_data,
        input  busy,
        input  done,
        input  rd_en,
        input  rd_addr,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  nz_count
    );
endinterface

// File: rtl/csd_conv_ctrl.sv
// Bit-serial binary-to-CSD recoding controller: reads an N-bit operand LSB
// first, writes N+1 signed digits (00=0, 01=+1, 11=-1) and a nonzero count.
module csd_conv_ctrl #(
    parameter int N  = 8,
    parameter int AW = 4
) (
    input  logic           clk,
    input  logic           reset,
    csd_conv_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_STEP,
        S_FLUSH,
        S_DONE
    } state_e;

    localparam logic [AW-1:0] LAST_IDX   = AW'(N - 1);
    localparam logic [AW-1:0] FLUSH_ADDR = AW'(N);
    localparam logic [AW:0]   LAST_RD    = (AW + 1)'(N - 1);

    state_e        state_q;
    logic [AW-1:0] cnt_q;
    logic          carry_q;
    logic          cur_q;
    logic          rd_en_q;
    logic [AW-1:0] rd_addr_q;
    logic          wr_en_q;
    logic [AW-1:0] wr_addr_q;
    logic [1:0]    wr_data_q;
    logic [AW-1:0] nz_q;

    logic          nxt_d;
    logic [1:0]    digit_d;
    logic          carry_d;
    logic [AW:0]   cnt_p2;
    logic          rd_more;

    // Read-ahead runs two digits ahead of the digit being emitted.
    assign cnt_p2  = {1'b0, cnt_q} + (AW + 1)'(2);
    assign rd_more = (cnt_p2 <= LAST_RD);

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    always_comb begin
        nxt_d   = (cnt_q != LAST_IDX) ? bus.rd_data : 1'b0;
        digit_d = 2'b00;
        carry_d = 1'b0;
        unique case ({cur_q, carry_q})
            2'b00: begin
                digit_d = 2'b00;
                carry_d = 1'b0;
            end
            2'b11: begin
                digit_d = 2'b00;
                carry_d = 1'b1;
            end
            default: begin
                // Lone one: a following one turns it into -1 with carry out.
                if (nxt_d) begin
                    digit_d = 2'b11;
                    carry_d = 1'b1;
                end else begin
                    digit_d = 2'b01;
                    carry_d = 1'b0;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            cur_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 2'b00;
            nz_q      <= '0;
        end else begin
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        cnt_q     <= '0;
                        carry_q   <= 1'b0;
                        nz_q      <= '0;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                        state_q   <= S_PRIME;
                    end
                end
                S_PRIME: begin
                    cur_q     <= bus.rd_data;
                    rd_en_q   <= 1'b1;
                    rd_addr_q <= AW'(1);
                    state_q   <= S_STEP;
                end
                S_STEP: begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= cnt_q;
                    wr_data_q <= digit_d;
                    nz_q      <= nz_q + AW'(digit_d[0]);
                    carry_q   <= carry_d;
                    cur_q     <= nxt_d;
                    if (rd_more) begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= cnt_p2[AW-1:0];
                    end
                    if (cnt_q == LAST_IDX) begin
                        state_q <= S_FLUSH;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                S_FLUSH: begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= FLUSH_ADDR;
                    wr_data_q <= {1'b0, carry_q};
                    nz_q      <= nz_q + AW'(carry_q);
                    state_q   <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.rd_en    = rd_en_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.nz_count = nz_q;

endmodule

// File: tb/tb_csd_conv_ctrl.sv
// Directed and random checks of csd_conv_ctrl against hand-computed CSD
// digit tables and an independent NAF formula (x vs 3x bit comparison).
module tb_csd_conv_ctrl;

    localparam int N  = 8;
    localparam int AW = 4;
    localparam int DW = 2 * (N + 1);

    logic clk = 1'b0;
    logic reset;

    csd_conv_ctrl_if #(.AW(AW)) bus ();

    csd_conv_ctrl #(.N(N), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic       src_mem [16];
    logic [1:0] kmem    [16];
    int         cyc = 0;
    int         wr_cnt = 0;
    int         busy_cnt = 0;
    int         bad10 = 0;
    int         oob = 0;
    int         wr_addr_log [16];
    int         wr_cyc_log  [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Source memory: registered read, data valid at the next active edge.
    always @(negedge clk) begin
        if (bus.rd_en) bus.rd_data <= src_mem[bus.rd_addr];
    end

    // Write/read monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.busy) busy_cnt++;
            if (bus.wr_en) begin
                kmem[bus.wr_addr] = bus.wr_data;
                if (wr_cnt < 16) begin
                    wr_addr_log[wr_cnt] = int'(bus.wr_addr);
                    wr_cyc_log[wr_cnt]  = cyc;
                end
                wr_cnt++;
                if (bus.wr_data == 2'b10) bad10++;
            end
            if (bus.rd_en && int'(bus.rd_addr) >= N) oob++;
        end
    end

    function automatic logic [DW-1:0] enc(input int d [N+1]);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i <= N; i++) begin
            if (d[i] == 1)       r[2*i +: 2] = 2'b01;
            else if (d[i] == -1) r[2*i +: 2] = 2'b11;
        end
        return r;
    endfunction

    // Non-adjacent form: +1 where 3x has a one x lacks, -1 where x has a one 3x lacks.
    function automatic logic [DW-1:0] naf_digits(input logic [N-1:0] x, output int nz);
        logic [N+1:0]  xx, x3, pos, neg;
        logic [DW-1:0] r;
        xx  = {2'b00, x};
        x3  = xx + (xx << 1);
        pos = (x3 & ~xx) >> 1;
        neg = (xx & ~x3) >> 1;
        r   = '0;
        nz  = 0;
        for (int i = 0; i <= N; i++) begin
            if (pos[i])      begin r[2*i +: 2] = 2'b01; nz++; end
            else if (neg[i]) begin r[2*i +: 2] = 2'b11; nz++; end
        end
        return r;
    endfunction

    task automatic load(input logic [N-1:0] op);
        for (int i = 0; i < 16; i++) src_mem[i] = (i < N) ? op[i] : 1'b0;
    endtask

    task automatic clear_logs();
        wr_cnt   = 0;
        busy_cnt = 0;
        for (int i = 0; i < 16; i++) kmem[i] = 2'b10;
    endtask

    // Returns with the cycle count right after the start edge, 1 ns past it.
    task automatic start_run(input logic [N-1:0] op, input bit hold, output int e0);
        clear_logs();
        load(op);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        e0 = cyc;
        if (!hold) bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int dcyc);
        bit found;
        found = 1'b0;
        dcyc  = -1;
        for (int k = 0; k < 64 && !found; k++) begin
            @(negedge clk);
            if (bus.done) begin
                found = 1'b1;
                dcyc  = cyc;
            end
        end
        #1;
        check({tag, "_done_seen"}, 32'(found), 32'd1);
    endtask

    task automatic verify(input string tag, input logic [N-1:0] op,
                          input logic [DW-1:0] exp_d, input int exp_nz);
        logic [DW-1:0] obs;
        int  s, adj;
        bit  addr_ok, cyc_ok;
        s = 0; adj = 0; addr_ok = 1'b1; cyc_ok = 1'b1;
        for (int i = 0; i <= N; i++) begin
            obs[2*i +: 2] = kmem[i];
            if (kmem[i] == 2'b01)      s += (1 << i);
            else if (kmem[i] == 2'b11) s -= (1 << i);
            else if (kmem[i] != 2'b00) s += 100000;
            if (i > 0 && kmem[i] != 2'b00 && kmem[i-1] != 2'b00) adj++;
        end
        for (int i = 0; i < wr_cnt && i < 16; i++) begin
            if (wr_addr_log[i] != i) addr_ok = 1'b0;
            if (i > 0 && wr_cyc_log[i] != wr_cyc_log[i-1] + 1) cyc_ok = 1'b0;
        end
        check({tag, "_digits"}, 32'(obs), 32'(exp_d));
        check({tag, "_nz_count"}, 32'(bus.nz_count), 32'(exp_nz));
        check({tag, "_writes"}, 32'(wr_cnt), 32'(N + 1));
        check({tag, "_addr_order"}, 32'(addr_ok), 32'd1);
        check({tag, "_no_gaps"}, 32'(cyc_ok), 32'd1);
        check({tag, "_sum"}, 32'(s), 32'(op));
        check({tag, "_adjacent_nz"}, 32'(adj), 32'd0);
    endtask

    int d_ab [N+1] = '{-1, 0, -1, 0, -1, 0, -1, 0, 1};
    int d_07 [N+1] = '{-1, 0, 0, 1, 0, 0, 0, 0, 0};
    int d_ff [N+1] = '{-1, 0, 0, 0, 0, 0, 0, 0, 1};
    int d_00 [N+1] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        int e0, d1, d2, nz;
        logic [N-1:0]  op;
        logic [DW-1:0] ed;

        bus.start   = 1'b0;
        bus.rd_data = 1'b0;
        reset       = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rd_en", 32'(bus.rd_en), 32'd0);
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_outputs", {bus.rd_addr, bus.wr_addr, bus.nz_count, bus.wr_data}, 32'd0);
        reset = 1'b0;

        // 0xAB with latency: done occupies the 11th cycle from the start edge.
        start_run(8'hAB, 1'b0, e0);
        wait_done("ab", d1);
        check("ab_done_latency", 32'(d1 - e0), 32'(N + 2));
        check("ab_busy_cycles", 32'(busy_cnt), 32'(N + 3));
        verify("ab", 8'hAB, enc(d_ab), 5);
        @(negedge clk);
        check("ab_done_pulse", 32'(bus.done), 32'd0);

        start_run(8'h07, 1'b0, e0);
        wait_done("x07", d1);
        verify("x07", 8'h07, enc(d_07), 2);

        start_run(8'hFF, 1'b0, e0);
        wait_done("xff", d1);
        verify("xff", 8'hFF, enc(d_ff), 2);

        start_run(8'h00, 1'b0, e0);
        wait_done("x00", d1);
        verify("x00", 8'h00, enc(d_00), 0);

        // start held high: second run starts right after the idle cycle.
        start_run(8'hAB, 1'b1, e0);
        wait_done("hold1", d1);
        verify("hold1", 8'hAB, enc(d_ab), 5);
        clear_logs();
        @(posedge clk);
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done("hold2", d2);
        check("hold_restart_gap", 32'(d2 - d1), 32'(N + 4));
        verify("hold2", 8'hAB, enc(d_ab), 5);

        // start pulse mid-run is ignored.
        start_run(8'h07, 1'b0, e0);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("midstart", d1);
        verify("midstart", 8'h07, enc(d_07), 2);
        repeat (4) @(negedge clk);
        check("midstart_no_requeue", 32'(bus.busy), 32'd0);

        // Reset while in STEP with cnt = 3.
        start_run(8'hAB, 1'b0, e0);
        repeat (4) @(posedge clk);
        #2;
        check("prereset_wr_en", 32'(bus.wr_en), 32'd1);
        reset = 1'b1;
        #1;
        check("midreset_busy", 32'(bus.busy), 32'd0);
        check("midreset_wr_en", 32'(bus.wr_en), 32'd0);
        check("midreset_rd_en", 32'(bus.rd_en), 32'd0);
        check("midreset_nz", 32'(bus.nz_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        start_run(8'hAB, 1'b0, e0);
        wait_done("postreset", d1);
        verify("postreset", 8'hAB, enc(d_ab), 5);

        for (int r = 0; r < 200; r++) begin
            op = 8'($urandom_range(0, 255));
            ed = naf_digits(op, nz);
            start_run(op, 1'b0, e0);
            wait_done("rand", d1);
            verify("rand", op, ed, nz);
        end

        check("never_wr_10", 32'(bad10), 32'd0);
        check("rd_addr_in_range", 32'(oob), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
